// File: rtl/mem_port_unit.sv
// Memory-port stage in front of the microcoded controller: turns per-state
// MemRead/MemWrite requests into one handshaked access and owns the IR and MDR.
module mem_port_unit #(
   parameter int WORD_SIZE = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] pc,
   input  logic [WORD_SIZE-1:0] alu_out,
   input  logic [WORD_SIZE-1:0] write_data,
   input  logic                 IorD,
   input  logic                 MemRead,
   input  logic                 MemWrite,
   input  logic                 IRWrite,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   input  logic                 mem_ready,
   output logic [WORD_SIZE-1:0] inst,
   output logic [WORD_SIZE-1:0] mdr,
   output logic                 mem_busy,
   output logic                 bus_error
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   // The wait counter times out on the cycle it already holds TIMEOUT-1.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t               state_reg, state_next;
   logic [7:0]           cnt_reg;
   logic                 op_write_reg, dest_reg;
   logic                 read_strobe_reg, write_strobe_reg;
   logic                 bus_error_reg;
   logic [WORD_SIZE-1:0] address_reg, wdata_reg, inst_reg, mdr_reg;

   logic start_req, finish_ok, finish_timeout;

   always_comb begin
      state_next     = state_reg;
      mem_busy       = 1'b0;
      start_req      = 1'b0;
      finish_ok      = 1'b0;
      finish_timeout = 1'b0;
      case (state_reg)
         IDLE: begin
            if (MemRead || MemWrite) begin
               mem_busy   = 1'b1;
               start_req  = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            mem_busy = 1'b1;
            if (mem_ready) begin
               finish_ok  = 1'b1;
               state_next = DONE;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               finish_timeout = 1'b1;
               state_next     = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg          <= 8'd0;
         op_write_reg     <= 1'b0;
         dest_reg         <= 1'b0;
         read_strobe_reg  <= 1'b0;
         write_strobe_reg <= 1'b0;
         bus_error_reg    <= 1'b0;
         address_reg      <= '0;
         wdata_reg        <= '0;
         inst_reg         <= '0;
         mdr_reg          <= '0;
      end else begin
         if (start_req) begin
            // A simultaneous read+write request is resolved as a write and flagged.
            address_reg      <= IorD ? alu_out : pc;
            wdata_reg        <= write_data;
            op_write_reg     <= MemWrite;
            dest_reg         <= IRWrite;
            cnt_reg          <= 8'd0;
            read_strobe_reg  <= ~MemWrite;
            write_strobe_reg <= MemWrite;
            if (MemRead && MemWrite) begin
               bus_error_reg <= 1'b1;
            end
         end else if (state_reg == REQ && !finish_ok && !finish_timeout) begin
            cnt_reg <= cnt_reg + 8'd1;
         end

         if (finish_ok || finish_timeout) begin
            read_strobe_reg  <= 1'b0;
            write_strobe_reg <= 1'b0;
         end
         if (finish_timeout) begin
            bus_error_reg <= 1'b1;
         end
         if (finish_ok && !op_write_reg) begin
            if (dest_reg) begin
               inst_reg <= mem_rdata;
            end else begin
               mdr_reg <= mem_rdata;
            end
         end
      end
   end

   assign readM     = read_strobe_reg;
   assign writeM    = write_strobe_reg;
   assign address   = address_reg;
   assign mem_wdata = wdata_reg;
   assign inst      = inst_reg;
   assign mdr       = mdr_reg;
   assign bus_error = bus_error_reg;

endmodule

// File: tb/tb_mem_port_unit.sv
// Directed bench for mem_port_unit: fetch, load, store, timeout, conflict and
// reset-in-flight sequences, each with hand-computed expectations.
module tb_mem_port_unit;

   logic        clk;
   logic        reset_n;
   logic [15:0] pc, alu_out, write_data, mem_rdata;
   logic        IorD, MemRead, MemWrite, IRWrite, mem_ready;
   logic        readM, writeM, mem_busy, bus_error;
   logic [15:0] address, mem_wdata, inst, mdr;

   int passed = 0;
   int total  = 0;

   mem_port_unit #(.WORD_SIZE(16), .TIMEOUT(4)) dut (
      .clk(clk), .reset_n(reset_n), .pc(pc), .alu_out(alu_out),
      .write_data(write_data), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .readM(readM), .writeM(writeM),
      .address(address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .inst(inst), .mdr(mdr), .mem_busy(mem_busy),
      .bus_error(bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Each call lands 2 time units after a rising edge: the start of a new cycle.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0;
      mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle_inputs();
      step(); step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      pc = 16'h0; alu_out = 16'h0; write_data = 16'h0; mem_rdata = 16'h0;
      idle_inputs();
      reset_n = 1'b0;
      step(); step();
      #1;
      chkb("rst_readM", readM, 1'b0);
      chkb("rst_writeM", writeM, 1'b0);
      chkb("rst_bus_error", bus_error, 1'b0);
      chk("rst_address", address, 16'h0000);
      chk("rst_mem_wdata", mem_wdata, 16'h0000);
      chk("rst_inst", inst, 16'h0000);
      chk("rst_mdr", mdr, 16'h0000);
      chkb("rst_mem_busy", mem_busy, 1'b0);
      reset_n = 1'b1;
      step();

      // Fetch: ready in cycle 2
      pc = 16'h0010; IorD = 1'b0; MemRead = 1'b1; IRWrite = 1'b1;
      #1;
      chkb("fetch_c0_busy", mem_busy, 1'b1);
      chkb("fetch_c0_readM", readM, 1'b0);
      step();
      pc = 16'h9999; IRWrite = 1'b0;
      #1;
      chkb("fetch_c1_readM", readM, 1'b1);
      chk("fetch_c1_address", address, 16'h0010);
      chkb("fetch_c1_busy", mem_busy, 1'b1);
      step();
      mem_ready = 1'b1; mem_rdata = 16'h6A05;
      #1;
      chkb("fetch_c2_readM", readM, 1'b1);
      chkb("fetch_c2_busy", mem_busy, 1'b1);
      step();
      mem_ready = 1'b0;
      #1;
      chk("fetch_c3_inst", inst, 16'h6A05);
      chk("fetch_c3_mdr", mdr, 16'h0000);
      chkb("fetch_c3_busy", mem_busy, 1'b0);
      chkb("fetch_c3_readM", readM, 1'b0);
      step();
      idle_inputs();
      #1;
      chkb("fetch_c4_busy", mem_busy, 1'b0);
      step();

      // Load: ready in cycle 1
      alu_out = 16'h0200; IorD = 1'b1; MemRead = 1'b1; IRWrite = 1'b0;
      step();
      mem_ready = 1'b1; mem_rdata = 16'hBEEF;
      #1;
      chk("load_c1_address", address, 16'h0200);
      chkb("load_c1_readM", readM, 1'b1);
      step();
      mem_ready = 1'b0;
      #1;
      chk("load_c2_mdr", mdr, 16'hBEEF);
      chk("load_c2_inst", inst, 16'h6A05);
      chkb("load_c2_busy", mem_busy, 1'b0);
      step();
      idle_inputs();
      step();

      // Store: ready in cycle 4
      alu_out = 16'h0300; write_data = 16'h1234; IorD = 1'b1; MemWrite = 1'b1;
      mem_rdata = 16'hDEAD;
      step();
      #1;
      chkb("store_c1_writeM", writeM, 1'b1);
      chkb("store_c1_readM", readM, 1'b0);
      chk("store_c1_wdata", mem_wdata, 16'h1234);
      chk("store_c1_address", address, 16'h0300);
      step(); step();
      #1;
      chkb("store_c3_writeM", writeM, 1'b1);
      step();
      mem_ready = 1'b1;
      #1;
      chkb("store_c4_writeM", writeM, 1'b1);
      chkb("store_c4_busy", mem_busy, 1'b1);
      step();
      mem_ready = 1'b0;
      #1;
      chkb("store_c5_writeM", writeM, 1'b0);
      chkb("store_c5_busy", mem_busy, 1'b0);
      chk("store_c5_mdr", mdr, 16'hBEEF);
      chk("store_c5_inst", inst, 16'h6A05);
      chkb("store_c5_bus_error", bus_error, 1'b0);
      step();
      idle_inputs();
      step();

      // Timeout (TIMEOUT=4): read never acknowledged
      pc = 16'h0040; IorD = 1'b0; MemRead = 1'b1; IRWrite = 1'b0;
      step(); step(); step(); step();
      #1;
      chkb("to_c4_readM", readM, 1'b1);
      chkb("to_c4_busy", mem_busy, 1'b1);
      step();
      #1;
      chkb("to_c5_busy", mem_busy, 1'b0);
      chkb("to_c5_readM", readM, 1'b0);
      chkb("to_c5_bus_error", bus_error, 1'b1);
      chk("to_c5_mdr", mdr, 16'hBEEF);
      chk("to_c5_inst", inst, 16'h6A05);
      step();
      idle_inputs();
      mem_ready = 1'b1; mem_rdata = 16'h4444;
      step();
      mem_ready = 1'b0;
      step();
      #1;
      chkb("to_sticky", bus_error, 1'b1);
      chk("to_idle_ready_ignored", mdr, 16'hBEEF);

      do_reset();
      #1;
      chkb("reset_clears_error", bus_error, 1'b0);

      // Conflict: read and write together
      alu_out = 16'h0400; write_data = 16'h5555; IorD = 1'b1;
      MemRead = 1'b1; MemWrite = 1'b1; mem_rdata = 16'h3333;
      step();
      mem_ready = 1'b1;
      #1;
      chkb("conf_c1_writeM", writeM, 1'b1);
      chkb("conf_c1_readM", readM, 1'b0);
      chkb("conf_c1_bus_error", bus_error, 1'b1);
      chk("conf_c1_wdata", mem_wdata, 16'h5555);
      step();
      mem_ready = 1'b0;
      #1;
      chk("conf_c2_mdr", mdr, 16'h0000);
      chk("conf_c2_inst", inst, 16'h0000);
      chkb("conf_c2_busy", mem_busy, 1'b0);
      step();
      idle_inputs();
      do_reset();

      // Reset asserted in cycle 2 of a fetch
      pc = 16'h0020; IorD = 1'b0; MemRead = 1'b1; IRWrite = 1'b1;
      step(); step();
      #1;
      chkb("rmid_c2_readM", readM, 1'b1);
      reset_n = 1'b0;
      #1;
      chkb("rmid_readM_drop", readM, 1'b0);
      chk("rmid_address", address, 16'h0000);
      chk("rmid_inst", inst, 16'h0000);
      idle_inputs();
      #1;
      chkb("rmid_busy", mem_busy, 1'b0);
      step();
      reset_n = 1'b1;
      step();
      pc = 16'h0030; MemRead = 1'b1; IRWrite = 1'b1;
      step();
      mem_ready = 1'b1; mem_rdata = 16'h7777;
      #1;
      chk("rmid_refetch_address", address, 16'h0030);
      step();
      mem_ready = 1'b0;
      #1;
      chk("rmid_refetch_inst", inst, 16'h7777);
      chkb("rmid_refetch_busy", mem_busy, 1'b0);
      step();
      idle_inputs();
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
